// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if: instruction-in / immediate-out handshake bundle.
//   master : producer/consumer side (drives in_valid, inst_code, flush, out_ready)
//   slave  : imm_gen_pipe side (drives in_ready, out_valid, Imm_out, fmt,
//            illegal, illegal_cnt)
interface imm_gen_pipe_if #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      inst_code;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  Imm_out;
   logic [2:0]       fmt;
   logic             illegal;
   logic [CNT_W-1:0] illegal_cnt;

   modport master (
      output in_valid, inst_code, flush, out_ready,
      input  in_ready, out_valid, Imm_out, fmt, illegal, illegal_cnt
   );

   modport slave (
      input  in_valid, inst_code, flush, out_ready,
      output in_ready, out_valid, Imm_out, fmt, illegal, illegal_cnt
   );
endinterface

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RV immediate generator behind a valid/ready pipeline stage
// with an output register and one skid register.
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : imm_gen_pipe_if.slave
//           in_valid/in_ready/inst_code : instruction input handshake
//           flush                       : synchronous kill of all held beats
//           out_valid/out_ready         : result handshake
//           Imm_out/fmt/illegal         : decoded result (held while invalid)
//           illegal_cnt                 : saturating count of accepted illegal beats
module imm_gen_pipe #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 16
) (
   input logic          clk,
   input logic          reset,
   imm_gen_pipe_if.slave bus
);

   typedef enum logic [2:0] {
      FMT_NONE = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5
   } fmt_e;

   logic [31:0] inst;
   assign inst = bus.inst_code;

   // Each immediate is built XLEN wide directly; replication counts stay
   // positive for both legal XLEN values.
   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   assign imm_i = {{(XLEN-11){inst[31]}}, inst[30:20]};
   assign imm_s = {{(XLEN-11){inst[31]}}, inst[30:25], inst[11:7]};
   assign imm_b = {{(XLEN-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
   assign imm_u = {{(XLEN-31){inst[31]}}, inst[30:12], 12'b0};
   assign imm_j = {{(XLEN-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};

   logic [XLEN-1:0] dec_imm;
   fmt_e            dec_fmt;
   logic            dec_ill;

   always_comb begin
      dec_imm = '0;
      dec_fmt = FMT_NONE;
      dec_ill = 1'b0;
      case (inst[6:0])
         7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: begin
            dec_fmt = FMT_I;
            dec_imm = imm_i;
         end
         7'b0100011: begin
            dec_fmt = FMT_S;
            dec_imm = imm_s;
         end
         7'b1100011: begin
            dec_fmt = FMT_B;
            dec_imm = imm_b;
         end
         7'b0110111, 7'b0010111: begin
            dec_fmt = FMT_U;
            dec_imm = imm_u;
         end
         7'b1101111: begin
            dec_fmt = FMT_J;
            dec_imm = imm_j;
         end
         7'b0110011: ;   // R-type: legal, no immediate
         7'b0011011: begin
            // OP-IMM-32 only exists on RV64
            if (XLEN == 64) begin
               dec_fmt = FMT_I;
               dec_imm = imm_i;
            end else begin
               dec_ill = 1'b1;
            end
         end
         default: dec_ill = 1'b1;
      endcase
   end

   logic             out_valid_q, skid_valid_q, in_ready_q;
   logic [XLEN-1:0]  out_imm_q, skid_imm_q;
   fmt_e             out_fmt_q, skid_fmt_q;
   logic             out_ill_q, skid_ill_q;
   logic [CNT_W-1:0] cnt_q;

   logic accept, out_free;
   assign accept   = bus.in_valid && in_ready_q && !bus.flush;
   assign out_free = !out_valid_q || bus.out_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
         in_ready_q   <= 1'b0;
         out_imm_q    <= '0;
         out_fmt_q    <= FMT_NONE;
         out_ill_q    <= 1'b0;
         skid_imm_q   <= '0;
         skid_fmt_q   <= FMT_NONE;
         skid_ill_q   <= 1'b0;
         cnt_q        <= '0;
      end else begin
         in_ready_q <= 1'b1;
         if (bus.flush) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
         end else begin
            if (out_free) begin
               // in_ready mirrors skid-empty, so a skid beat and a new
               // accept never compete for the output register.
               if (skid_valid_q) begin
                  out_imm_q    <= skid_imm_q;
                  out_fmt_q    <= skid_fmt_q;
                  out_ill_q    <= skid_ill_q;
                  out_valid_q  <= 1'b1;
                  skid_valid_q <= 1'b0;
               end else if (accept) begin
                  out_imm_q   <= dec_imm;
                  out_fmt_q   <= dec_fmt;
                  out_ill_q   <= dec_ill;
                  out_valid_q <= 1'b1;
               end else begin
                  out_valid_q <= 1'b0;
               end
            end else begin
               if (accept) begin
                  skid_imm_q   <= dec_imm;
                  skid_fmt_q   <= dec_fmt;
                  skid_ill_q   <= dec_ill;
                  skid_valid_q <= 1'b1;
               end
               in_ready_q <= !(skid_valid_q || accept);
            end
            if (accept && dec_ill && (cnt_q != '1))
               cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   assign bus.in_ready    = in_ready_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.Imm_out     = out_imm_q;
   assign bus.fmt         = out_fmt_q;
   assign bus.illegal     = out_ill_q;
   assign bus.illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: drives an XLEN=32 and an XLEN=64 (4-bit counter) instance
// with identical stimulus and checks both against a depth-2 FIFO reference.
module tb_imm_gen_pipe;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] inst = 32'h0;
   logic        flush = 1'b0;
   logic        out_ready = 1'b0;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   imm_gen_pipe_if #(.XLEN(32), .CNT_W(16)) bus32 ();
   imm_gen_pipe_if #(.XLEN(64), .CNT_W(4))  bus64 ();

   assign bus32.in_valid  = in_valid;
   assign bus32.inst_code = inst;
   assign bus32.flush     = flush;
   assign bus32.out_ready = out_ready;
   assign bus64.in_valid  = in_valid;
   assign bus64.inst_code = inst;
   assign bus64.flush     = flush;
   assign bus64.out_ready = out_ready;

   imm_gen_pipe #(.XLEN(32), .CNT_W(16)) dut32 (.clk(clk), .reset(reset), .bus(bus32));
   imm_gen_pipe #(.XLEN(64), .CNT_W(4))  dut64 (.clk(clk), .reset(reset), .bus(bus64));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference decode straight from the instruction-set field layouts.
   function automatic void ref_dec(input logic [31:0] i, input int xlen,
                                   output logic [63:0] imm, output logic [2:0] f,
                                   output logic ill);
      longint v;
      v = 0; f = 3'd0; ill = 1'b0;
      case (i[6:0])
         7'h03, 7'h13, 7'h67, 7'h73: begin f = 3'd1; v = longint'($signed(i[31:20])); end
         7'h23: begin f = 3'd2; v = longint'($signed({i[31:25], i[11:7]})); end
         7'h63: begin f = 3'd3; v = longint'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0})); end
         7'h37, 7'h17: begin f = 3'd4; v = longint'($signed({i[31:12], 12'h000})); end
         7'h6F: begin f = 3'd5; v = longint'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0})); end
         7'h33: ;
         7'h1B: if (xlen == 64) begin f = 3'd1; v = longint'($signed(i[31:20])); end
                else ill = 1'b1;
         default: ill = 1'b1;
      endcase
      imm = v;
   endfunction

   // Behavioural model: the stage is a 2-entry in-order FIFO.
   logic [31:0] q[$];
   logic [31:0] shown = 32'h0;
   bit          shown_none = 1'b1;
   bit          m_ready = 1'b0;
   int          cnt32 = 0;
   int          cnt64 = 0;

   always @(posedge clk or posedge reset) begin
      logic [63:0] di; logic [2:0] df; logic dl;
      if (reset) begin
         q.delete();
         shown_none = 1'b1;
         m_ready = 1'b0;
         cnt32 = 0;
         cnt64 = 0;
      end else begin
         if (flush) q.delete();
         else begin
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            if (in_valid && m_ready) begin
               q.push_back(inst);
               ref_dec(inst, 32, di, df, dl);
               if (dl && cnt32 < 65535) cnt32++;
               ref_dec(inst, 64, di, df, dl);
               if (dl && cnt64 < 15) cnt64++;
            end
         end
         if (q.size() > 0) begin
            shown_none = 1'b0;
            shown = q[0];
         end
         m_ready = (q.size() < 2);
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      logic [63:0] ei; logic [2:0] ef; logic el;
      chk("valid32", 64'(bus32.out_valid), 64'(q.size() > 0));
      chk("valid64", 64'(bus64.out_valid), 64'(q.size() > 0));
      chk("ready32", 64'(bus32.in_ready), 64'(m_ready));
      chk("ready64", 64'(bus64.in_ready), 64'(m_ready));
      chk("cnt32", 64'(bus32.illegal_cnt), 64'(cnt32));
      chk("cnt64", 64'(bus64.illegal_cnt), 64'(cnt64));
      if (shown_none) begin ei = '0; ef = '0; el = 1'b0; end
      else ref_dec(shown, 32, ei, ef, el);
      chk("imm32", 64'(bus32.Imm_out), {32'h0, ei[31:0]});
      chk("fmt32", 64'(bus32.fmt), 64'(ef));
      chk("ill32", 64'(bus32.illegal), 64'(el));
      if (!shown_none) ref_dec(shown, 64, ei, ef, el);
      chk("imm64", bus64.Imm_out, ei);
      chk("fmt64", 64'(bus64.fmt), 64'(ef));
      chk("ill64", 64'(bus64.illegal), 64'(el));
   end

   task automatic drive(input logic v, input logic [31:0] i, input logic f, input logic r);
      @(negedge clk);
      in_valid = v; inst = i; flush = f; out_ready = r;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rand_inst();
      logic [6:0] ops [11];
      int k;
      logic [31:0] r;
      ops = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h1B};
      r = $urandom;
      k = $urandom_range(0, 11);
      if (k == 11) return r;
      return {r[31:7], ops[k]};
   endfunction

   localparam logic [31:0] IA = 32'hFE000EE3;  // beq -4
   localparam logic [31:0] IB = 32'hFF9FF06F;  // jal -8
   localparam logic [31:0] IC = 32'h123450B7;  // lui 0x12345

   initial begin
      logic [63:0] pi; logic [2:0] pf; logic pl;

      // Literal pins of the reference decoder itself
      ref_dec(IA, 32, pi, pf, pl);
      chk("model_beq", pi, 64'hFFFFFFFFFFFFFFFC);
      chk("model_beq_fmt", 64'(pf), 64'd3);
      ref_dec(IB, 32, pi, pf, pl);
      chk("model_jal", pi, 64'hFFFFFFFFFFFFFFF8);
      ref_dec(IC, 32, pi, pf, pl);
      chk("model_lui", pi, 64'h12345000);
      ref_dec(32'h800000B7, 64, pi, pf, pl);
      chk("model_lui64", pi, 64'hFFFFFFFF80000000);
      ref_dec(32'h0, 32, pi, pf, pl);
      chk("model_zero_ill", 64'(pl), 64'd1);

      #1 reset = 1'b1;
      #2;
      chk("rst_valid", 64'(bus32.out_valid), 64'd0);
      chk("rst_ready", 64'(bus32.in_ready), 64'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      drive(1'b0, 32'h0, 1'b0, 1'b1);
      chk("first_ready", 64'(bus32.in_ready), 64'd1);

      // Three-cycle stall with A, B, C back to back
      drive(1'b1, IA, 1'b0, 1'b0);
      chk("A_valid", 64'(bus32.out_valid), 64'd1);
      chk("A_imm32", 64'(bus32.Imm_out), 64'hFFFFFFFC);
      chk("A_fmt", 64'(bus32.fmt), 64'd3);
      chk("A_imm64", bus64.Imm_out, 64'hFFFFFFFFFFFFFFFC);
      drive(1'b1, IB, 1'b0, 1'b0);
      chk("B_skid_ready", 64'(bus32.in_ready), 64'd0);
      chk("A_hold", 64'(bus32.Imm_out), 64'hFFFFFFFC);
      drive(1'b1, IC, 1'b0, 1'b0);
      chk("C_held_off", 64'(bus32.in_ready), 64'd0);
      drive(1'b1, IC, 1'b0, 1'b1);
      chk("B_out", 64'(bus32.Imm_out), 64'hFFFFFFF8);
      chk("B_fmt", 64'(bus32.fmt), 64'd5);
      drive(1'b1, IC, 1'b0, 1'b1);
      chk("C_out", 64'(bus32.Imm_out), 64'h12345000);
      chk("C_fmt", 64'(bus32.fmt), 64'd4);
      drive(1'b0, 32'h0, 1'b0, 1'b1);
      chk("drain_valid", 64'(bus32.out_valid), 64'd0);
      chk("drain_hold", 64'(bus32.Imm_out), 64'h12345000);

      // Illegal beat, then flush while stalled with a same-cycle input
      drive(1'b1, 32'h0, 1'b0, 1'b0);
      chk("ill_flag", 64'(bus32.illegal), 64'd1);
      chk("ill_imm", 64'(bus32.Imm_out), 64'd0);
      chk("ill_cnt", 64'(bus32.illegal_cnt), 64'd1);
      drive(1'b1, IA, 1'b1, 1'b0);
      chk("flush_valid", 64'(bus32.out_valid), 64'd0);
      chk("flush_cnt", 64'(bus32.illegal_cnt), 64'd1);
      chk("flush_ready", 64'(bus32.in_ready), 64'd1);

      drive(1'b1, 32'h800000B7, 1'b0, 1'b1);
      chk("lui64", bus64.Imm_out, 64'hFFFFFFFF80000000);
      chk("lui32", 64'(bus32.Imm_out), 64'h80000000);
      drive(1'b1, 32'h0010009B, 1'b0, 1'b1);   // addiw x1,x0,1
      chk("addiw32_ill", 64'(bus32.illegal), 64'd1);
      chk("addiw32_cnt", 64'(bus32.illegal_cnt), 64'd2);
      chk("addiw64_imm", bus64.Imm_out, 64'd1);
      chk("addiw64_fmt", 64'(bus64.fmt), 64'd1);

      // Reset asserted mid-stall, away from any clock edge
      drive(1'b1, 32'h0, 1'b0, 1'b0);
      drive(1'b1, IB, 1'b0, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk("arst_valid", 64'(bus32.out_valid), 64'd0);
      chk("arst_cnt", 64'(bus32.illegal_cnt), 64'd0);
      chk("arst_cnt64", 64'(bus64.illegal_cnt), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      drive(1'b0, 32'h0, 1'b0, 1'b1);
      chk("arst_ready", 64'(bus32.in_ready), 64'd1);

      // Randomized traffic with occasional flush and reset
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 6);
         flush     = ($urandom_range(0, 24) == 0);
         inst      = rand_inst();
         if (c % 700 == 350) #2 reset = 1'b1;
         if (c % 700 == 352) reset = 1'b0;
      end
      @(negedge clk);
      reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (4) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width of the immediate; legal values 32 and 64.
REQ-002 SHALL have parameter CNT_W, default 16, width of the illegal-instruction counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, asserted when inst_code carries an instruction.
REQ-006 SHALL have port in_ready, output, 1, block can accept an instruction this cycle.
REQ-007 SHALL have port inst_code, input, 32, instruction word.
REQ-008 SHALL have port flush, input, 1, synchronous pipeline kill.
REQ-009 SHALL have port out_valid, output, 1, Imm_out, fmt and illegal hold a valid result.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts the result this cycle.
REQ-011 SHALL have port Imm_out, output, XLEN, sign-extended immediate.
REQ-012 SHALL have port fmt, output, 3, format code: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J.
REQ-013 SHALL have port illegal, output, 1, opcode not recognised.
REQ-014 SHALL have port illegal_cnt, output, CNT_W, count of accepted illegal instructions.

Function
REQ-015 SHALL decode opcode inst_code[6:0] as follows:
- 0000011, 0010011, 1100111, 1110011 -> I
- 0100011 -> S
- 1100011 -> B
- 0110111, 0010111 -> U
- 1101111 -> J
- 0110011 -> NONE, imm 0, legal
- 0011011 -> I when XLEN=64, illegal when XLEN=32
REQ-016 SHALL form immediates per the RV32I base encodings and sign-extend from inst_code[31] to XLEN:
- U: {inst[31:12], 12'b0}
- B and J: bit 0 is 0
REQ-017 SHALL, for any other opcode or inst_code[1:0]!=2'b11, output Imm_out=0, fmt=0, illegal=1.
REQ-018 SHALL accept a beat when in_valid && in_ready && !flush.
REQ-019 SHALL present an accepted beat on the outputs one cycle after acceptance when the output register is empty or draining; latency 1.
REQ-020 SHALL contain an output register plus one skid register; in_ready SHALL be a registered signal equal to "skid empty".
REQ-021 SHALL hold outputs stable while out_valid && !out_ready.
REQ-022 SHALL capture a beat accepted during a stall into the skid register.
REQ-023 SHALL move the skid contents to the output register on the cycle the output is consumed.
REQ-024 SHALL preserve in-order delivery, with no loss or duplication.
REQ-025 SHALL, on flush, clear out_valid and the skid next edge, discard any same-cycle input, and raise in_ready next cycle; flush has priority over all other events.
REQ-026 SHALL increment illegal_cnt on each accepted illegal beat and saturate at all-ones.
REQ-027 SHALL keep illegal_cnt unchanged by flush.
REQ-028 SHALL hold Imm_out, fmt and illegal at their last values when out_valid=0; only out_valid qualifies them.
REQ-029 SHALL, on simultaneous consume and accept with the skid empty, load the new beat directly into the output register.

Reset
REQ-030 SHALL, while reset=1, immediately force out_valid=0, skid empty, Imm_out=0, fmt=0, illegal=0, illegal_cnt=0.
REQ-031 SHALL hold in_ready=0 during reset and drive in_ready=1 on the first clk edge after reset deasserts.
REQ-032 SHALL discard any beat in flight when reset asserts mid-operation.

Verification
REQ-033 SHALL cover: XLEN=32, inst 0xFE000EE3 (beq -4), out_ready=1 -> next cycle out_valid=1, Imm_out=0xFFFFFFFC, fmt=3.
REQ-034 SHALL cover: inst 0xFF9FF06F (jal -8) -> Imm_out=0xFFFFFFF8, fmt=5; inst 0x123450B7 -> 0x12345000, fmt=4.
REQ-035 SHALL cover: XLEN=64, inst 0x800000B7 -> Imm_out=0xFFFFFFFF80000000, fmt=4.
REQ-036 SHALL cover: out_ready=0 for 3 cycles, inputs A, B, C back-to-back:
- A is held on the outputs and B goes into the skid; in_ready falls.
- C is held off at the input.
- On release A, B, C are delivered in order, with no loss.
REQ-037 SHALL cover: inst 0x00000000 accepted -> illegal=1, fmt=0, Imm_out=0, illegal_cnt=1; flush during the stall -> out_valid=0 next cycle, illegal_cnt stays 1.
REQ-038 SHALL cover: reset asserted mid-stall -> out_valid=0 without a clock edge, illegal_cnt=0.
